// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with double-buffered digit values,
// hex/decimal decode, leading-zero blanking and per-digit decimal points.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Segment vectors are {G,F,E,D,C,B,A}; codes 10-15 show "-" outside hex mode.
  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      4'd10:   s = hex ? 7'b1110111 : 7'b1000000;
      4'd11:   s = hex ? 7'b1111100 : 7'b1000000;
      4'd12:   s = hex ? 7'b0111001 : 7'b1000000;
      4'd13:   s = hex ? 7'b1011110 : 7'b1000000;
      4'd14:   s = hex ? 7'b1111001 : 7'b1000000;
      default: s = hex ? 7'b1110001 : 7'b1000000;
    endcase
    return s;
  endfunction

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    pend_val_q, pend_val_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]    act_val_q, act_val_d;
  logic [DIGITS-1:0]      act_dp_q, act_dp_d;
  logic                   wrap_q, wrap_d;
  logic [6:0]             seg_q, seg_d;
  logic                   seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   frame_done_q, frame_done_d;

  logic                   slot_end;
  logic                   frame_end;
  logic [3:0]             nib;
  logic [3:0]             code;
  logic                   cur_dp;
  logic                   lz_run;
  logic                   blank;

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_end  = slot_end && (idx_q == IDX_LAST);

    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp    : pend_dp_q;

    // A load coinciding with the frame boundary bypasses the pending buffer.
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (frame_end) begin
      act_val_d = load ? value : pend_val_q;
      act_dp_d  = load ? dp    : pend_dp_q;
    end

    // frame_done lines up with the first output cycle of the new digit-0 slot.
    wrap_d       = frame_end;
    frame_done_d = wrap_q;

    nib    = '0;
    cur_dp = 1'b0;
    lz_run = 1'b1;
    blank  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (act_val_q[4*k +: 4] == 4'd0);
      if (idx_q == IW'(k)) begin
        nib    = act_val_q[4*k +: 4];
        cur_dp = act_dp_q[k];
        blank  = blank_lz && (k != 0) && lz_run;
      end
    end

    // Nibbles arrive MSB-first in the low bit position.
    code     = {nib[0], nib[1], nib[2], nib[3]};
    seg_d    = blank ? 7'b0000000 : decode(code, hex_mode);
    seg_dp_d = cur_dp;

    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = (cnt_q != '0) && (idx_q == IW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      wrap_q       <= 1'b0;
      seg_q        <= '0;
      seg_dp_q     <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (DIGITS=4, PRESCALE=4): expected
// per-cycle outputs are queued by cycle number and compared by a monitor.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        hex_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_display #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp(dp),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg(seg), .seg_dp(seg_dp),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Patterns written A..G left to right.
  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S9 = 7'b1111011,
                         SB = 7'b0011111, SM = 7'b0000001, SZ = 7'b0000000;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       sdp;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] rev7(input logic [6:0] p);
    return {p[0], p[1], p[2], p[3], p[4], p[5], p[6]};
  endfunction

  function automatic logic [3:0] nibr(input logic [3:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] c3, input logic [3:0] c2,
                                       input logic [3:0] c1, input logic [3:0] c0);
    return {nibr(c3), nibr(c2), nibr(c1), nibr(c0)};
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_reset(input int c);
    exp_t e;
    e.cyc = c; e.an = 4'b0; e.seg = 7'b0; e.sdp = 1'b0; e.fd = 1'b0; e.tag = "reset";
    q.push_back(e);
  endtask

  // Expected outputs after edges base+mlo..base+mhi; m counts edges since reset released.
  task automatic push_range(input int base, input int mlo, input int mhi,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [3:0] dps, input string tag);
    logic [6:0] segs [4];
    exp_t e;
    segs[0] = rev7(s0); segs[1] = rev7(s1); segs[2] = rev7(s2); segs[3] = rev7(s3);
    for (int m = mlo; m <= mhi; m++) begin
      int s, p;
      s = ((m - 1) / 4) % 4;
      p = (m - 1) % 4;
      e.cyc = base + m;
      e.an  = (p == 0) ? 4'b0000 : 4'(1 << s);
      e.seg = segs[s];
      e.sdp = dps[s];
      e.fd  = (m > 1) && ((m - 1) % 16 == 0);
      e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input int at, input logic [15:0] v, input logic [3:0] d);
    wait_cyc(at);
    value = v;
    dp    = d;
    load  = 1'b1;
    wait_cyc(at + 1);
    load  = 1'b0;
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if ({an, seg, seg_dp, frame_done} !== {e.an, e.seg, e.sdp, e.fd}) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
               e.tag, cyc, an, seg, seg_dp, frame_done, e.an, e.seg, e.sdp, e.fd);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s missed cyc=%0d now=%0d", mon_e.tag, mon_e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; hex_mode = 1'b0; blank_lz = 1'b0;

    // Initial reset, then a mid-frame reset held for three cycles.
    for (int c = 1; c <= 3; c++) push_reset(c);
    push_range(3, 1, 36, S0, S0, S0, S0, 4'b0000, "scan_zero");
    for (int c = 40; c <= 42; c++) push_reset(c);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(39);
    reset = 1'b1;
    wait_cyc(42);
    reset = 1'b0;
    t0 = 42;
    push_range(t0, 1, 32, S0, S0, S0, S0, 4'b0000, "after_reset");

    // Mid-frame load of 1,2,3,4 shows only from frame 2.
    push_range(t0, 33, 48, S1, S2, S3, S4, 4'b0000, "dec_1234");
    apply_stimulus(t0 + 20, pack(4'd1, 4'd2, 4'd3, 4'd4), 4'b0000);

    // Code 11 in digit 0: hex then decimal.
    wait_cyc(t0 + 36);
    hex_mode = 1'b1;
    push_range(t0, 49, 64, S0, S0, S0, SB, 4'b0000, "hex_b");
    push_range(t0, 65, 80, S0, S0, S0, SM, 4'b0000, "dec_dash");
    apply_stimulus(t0 + 36, pack(4'd0, 4'd0, 4'd0, 4'd11), 4'b0000);
    wait_cyc(t0 + 64);
    hex_mode = 1'b0;

    // Leading-zero blanking.
    wait_cyc(t0 + 80);
    blank_lz = 1'b1;
    push_range(t0, 81, 96, SZ, SZ, SZ, SM, 4'b0000, "lz_dash");
    push_range(t0, 97, 112, SZ, SZ, SZ, S0, 4'b0000, "lz_0000");
    apply_stimulus(t0 + 80, pack(4'd0, 4'd0, 4'd0, 4'd0), 4'b0000);
    push_range(t0, 113, 128, SZ, S5, S0, S7, 4'b0000, "lz_0507");
    apply_stimulus(t0 + 100, pack(4'd0, 4'd5, 4'd0, 4'd7), 4'b0000);

    // Load exactly on the boundary, then one cycle later.
    push_range(t0, 129, 144, S9, S9, S9, S9, 4'b0000, "boundary_9999");
    push_range(t0, 145, 160, S3, S0, S6, S1, 4'b0000, "late_3061");
    apply_stimulus(t0 + 127, pack(4'd9, 4'd9, 4'd9, 4'd9), 4'b0000);
    apply_stimulus(t0 + 128, pack(4'd3, 4'd0, 4'd6, 4'd1), 4'b0000);

    // Decimal point survives blanking.
    push_range(t0, 161, 176, SZ, SZ, SZ, S0, 4'b0100, "dp_blank");
    apply_stimulus(t0 + 150, pack(4'd0, 4'd0, 4'd0, 4'd0), 4'b0100);

    wait_cyc(t0 + 178);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
